// File: rtl/scan_bist_pkg.sv
// Shared definitions for the scan BIST controller: FSM state encoding,
// default chain length, LFSR/MISR tap masks and the common shift helper.
package scan_bist_pkg;

  localparam int         CHAIN_LEN_DEF = 8;
  localparam logic [7:0] LFSR_TAPS     = 8'h8E;  // bits 7,3,2,1
  localparam logic [7:0] MISR_TAPS     = 8'h8E;  // bits 7,3,2,1

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_DONE
  } state_t;

  // Left shift with XOR feedback of the tapped bits plus an injected bit.
  // The LFSR uses b=0; the MISR injects the unloaded response bit.
  function automatic logic [7:0] shift8(input logic [7:0] v,
                                        input logic [7:0] taps,
                                        input logic       b);
    return {v[6:0], (^(v & taps)) ^ b};
  endfunction

endpackage

// File: rtl/scan_bist_if.sv
// Session control and scan-chain bundle.
//   master: drives start/seed/num_patterns and the chain's scan_out_chain
//   slave : the controller; drives scan_in/scan_en/busy/done/signature
interface scan_bist_if;
  logic       start;
  logic [7:0] seed;
  logic [3:0] num_patterns;
  logic       scan_out_chain;
  logic       scan_in;
  logic       scan_en;
  logic       busy;
  logic       done;
  logic [7:0] signature;

  modport master (
    output start, seed, num_patterns, scan_out_chain,
    input  scan_in, scan_en, busy, done, signature
  );

  modport slave (
    input  start, seed, num_patterns, scan_out_chain,
    output scan_in, scan_en, busy, done, signature
  );
endinterface

// File: rtl/scan_bist_controller_misr8.sv
// 8-bit MISR compacting the unloaded scan response.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to 8'h00 (session start)
//   en         : absorb bit_in this cycle
//   sig        : current signature
module misr8
  import scan_bist_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sig <= 8'h00;
    else if (clr) sig <= 8'h00;
    else if (en)  sig <= shift8(sig, MISR_TAPS, bit_in);
  end

endmodule

// File: rtl/scan_bist_controller.sv
// Scan BIST session controller. Per pattern: LOAD shifts the LFSR pattern
// into the chain MSB first, CAPTURE pulses one functional cycle, UNLOAD
// shifts the response out into the MISR, then the LFSR steps.
//   clk, rst_n : clock, async active-low reset
//   bus        : scan_bist_if.slave (start/seed/num_patterns in,
//                scan_in/scan_en/busy/done/signature out)
module scan_bist_controller
  import scan_bist_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  scan_bist_if.slave   bus
);

  // Counter must reach CHAIN_LEN (UNLOAD) and expose at least 3 bits
  // for the pattern bit index.
  localparam int CNT_RAW = $clog2(CHAIN_LEN + 2);
  localparam int CNT_W   = (CNT_RAW < 3) ? 3 : CNT_RAW;

  state_t             state, state_nxt;
  logic [7:0]         lfsr;
  logic [3:0]         pat_cnt;
  logic [CNT_W-1:0]   bit_cnt;
  logic               load_last, unload_last, accept;
  logic [2:0]         bit_idx;
  logic [7:0]         sig;

  assign accept      = (state == ST_IDLE) && bus.start;
  assign load_last   = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign unload_last = (bit_cnt == CNT_W'(CHAIN_LEN));
  assign bit_idx     = ~bit_cnt[2:0];  // 7 - bit_cnt: MSB goes out first

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (bus.start) state_nxt = (bus.num_patterns != 4'd0) ? ST_LOAD : ST_DONE;
      ST_LOAD:    if (load_last) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_UNLOAD;
      ST_UNLOAD:  if (unload_last) state_nxt = (pat_cnt == 4'd1) ? ST_DONE : ST_LOAD;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs, decoded from registers only
  always_comb begin
    bus.busy    = 1'b0;
    bus.scan_en = 1'b0;
    bus.scan_in = 1'b0;
    bus.done    = 1'b0;
    case (state)
      ST_LOAD: begin
        bus.busy    = 1'b1;
        bus.scan_en = 1'b1;
        bus.scan_in = lfsr[bit_idx];
      end
      ST_CAPTURE: bus.busy = 1'b1;
      ST_UNLOAD: begin
        bus.busy    = 1'b1;
        bus.scan_en = 1'b1;
      end
      ST_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  // Pattern LFSR, bit counter and pattern counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= 8'h00;
      pat_cnt <= 4'd0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          if (accept && bus.num_patterns != 4'd0) begin
            lfsr    <= bus.seed;
            pat_cnt <= bus.num_patterns;
          end
        end
        ST_LOAD: bit_cnt <= load_last ? '0 : bit_cnt + 1'b1;
        ST_UNLOAD: begin
          if (unload_last) begin
            bit_cnt <= '0;
            lfsr    <= shift8(lfsr, LFSR_TAPS, 1'b0);
            pat_cnt <= pat_cnt - 4'd1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

  // UNLOAD cycle 0 sees the chain's stale output register; skip it.
  misr8 u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     ((state == ST_UNLOAD) && (bit_cnt != '0)),
    .bit_in (bus.scan_out_chain),
    .sig    (sig)
  );

  assign bus.signature = sig;

endmodule

// File: tb/tb_scan_bist_controller.sv
// Scoreboard bench: each accepted session pushes its expected per-cycle
// output stream and final signature; a negedge monitor pops and compares.
// A behavioural 8-flop scan chain (capture = XOR with a random key, plus a
// registered serial output) or a tied-1/tied-0 source supplies responses.
module tb_scan_bist_controller;

  typedef struct packed {
    logic busy;
    logic scan_en;
    logic scan_in;
    logic done;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  scan_bist_if bus();

  scan_bist_controller #(.CHAIN_LEN(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  cyc_t       exp_q[$];
  logic [7:0] sig_q[$];
  cyc_t       mon_e;

  // Downstream chain model
  int         mode = 0;       // 0 = chain model, 1 = tied 1, 2 = tied 0
  logic [7:0] key  = 8'h00;
  logic [7:0] ch   = 8'h00;
  logic       out_q = 1'b0;

  always @(posedge clk) begin
    out_q <= ch[7];
    if (bus.scan_en) ch <= {ch[6:0], bus.scan_in};
    else             ch <= ch ^ key;
  end

  assign bus.scan_out_chain = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : out_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] p);
    return {p[6:0], p[1] ^ p[2] ^ p[3] ^ p[7]};
  endfunction

  function automatic logic [7:0] misr_step(input logic [7:0] s, input logic b);
    return {s[6:0], s[7] ^ s[3] ^ s[2] ^ s[1] ^ b};
  endfunction

  function automatic cyc_t mk(input logic b, input logic e, input logic i, input logic d);
    cyc_t c;
    c.busy = b; c.scan_en = e; c.scan_in = i; c.done = d;
    return c;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("busy",    {31'd0, bus.busy},    {31'd0, mon_e.busy});
        chk("scan_en", {31'd0, bus.scan_en}, {31'd0, mon_e.scan_en});
        chk("scan_in", {31'd0, bus.scan_in}, {31'd0, mon_e.scan_in});
        chk("done",    {31'd0, bus.done},    {31'd0, mon_e.done});
      end else begin
        chk("idle_done", {31'd0, bus.done}, 32'd0);
      end
      if (bus.done && sig_q.size() != 0)
        chk("signature", {24'd0, bus.signature}, {24'd0, sig_q.pop_front()});
    end
  end

  // Called at posedge+1 with the DUT idle. Returns the expected signature.
  task automatic session(input logic [7:0] sd, input logic [3:0] n, input int md,
                         input bit repulse, input bit done_poke,
                         output logic [7:0] sig_exp);
    logic [7:0] p, r, s;
    int last;
    mode = md;
    key  = 8'($urandom);
    bus.seed = sd; bus.num_patterns = n; bus.start = 1'b1;
    @(posedge clk); #1;
    p = sd; s = 8'h00;
    for (int k = 0; k < int'(n); k++) begin
      for (int b = 0; b < 8; b++) exp_q.push_back(mk(1'b1, 1'b1, p[7-b], 1'b0));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
      for (int b = 0; b < 9; b++) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
      r = (md == 1) ? 8'hFF : (md == 2) ? 8'h00 : (p ^ key);
      for (int b = 7; b >= 0; b--) s = misr_step(s, r[b]);
      p = lfsr_step(p);
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    sig_q.push_back(s);
    last = 18 * int'(n) + 3;
    for (int c = 1; c <= last; c++) begin
      bus.start = (repulse && n != 4'd0 && c == 2) || (done_poke && c == 18 * int'(n) + 1);
      bus.seed = 8'($urandom);
      bus.num_patterns = 4'($urandom);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("stream_drained", exp_q.size(), 32'd0);
    chk("sig_drained",    sig_q.size(), 32'd0);
    exp_q.delete();
    sig_q.delete();
    chk("sig_hold", {24'd0, bus.signature}, {24'd0, s});
    sig_exp = s;
  endtask

  initial begin
    logic [7:0] se;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.seed = 8'h00; bus.num_patterns = 4'd0;
    #1;
    chk("rst_busy",    {31'd0, bus.busy},    32'd0);
    chk("rst_scan_en", {31'd0, bus.scan_en}, 32'd0);
    chk("rst_scan_in", {31'd0, bus.scan_in}, 32'd0);
    chk("rst_done",    {31'd0, bus.done},    32'd0);
    chk("rst_sig",     {24'd0, bus.signature}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed sessions
    session(8'hBD, 4'd1, 0, 1'b0, 1'b0, se);       // reference load sequence
    session(8'hBD, 4'd1, 1, 1'b0, 1'b0, se);       // tied 1
    chk("sig_tied1", {24'd0, bus.signature}, 32'h0000_00DE);
    session(8'hBD, 4'd1, 2, 1'b0, 1'b0, se);       // tied 0
    chk("sig_tied0", {24'd0, bus.signature}, 32'd0);
    session(8'hBD, 4'd2, 0, 1'b0, 1'b0, se);       // second pattern 8'h7B
    session(8'h3C, 4'd0, 1, 1'b0, 1'b0, se);       // zero patterns
    chk("sig_zero_pat", {24'd0, bus.signature}, 32'd0);
    session(8'hA5, 4'd2, 0, 1'b1, 1'b0, se);       // start re-pulsed in LOAD
    session(8'h5A, 4'd1, 0, 1'b0, 1'b1, se);       // start during DONE
    session(8'h00, 4'd2, 1, 1'b0, 1'b0, se);       // LFSR lock-up seed

    // Reset during UNLOAD of pattern 1 of 3
    mode = 0;
    bus.seed = 8'h5A; bus.num_patterns = 4'd3; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy",    {31'd0, bus.busy},    32'd0);
    chk("abort_scan_en", {31'd0, bus.scan_en}, 32'd0);
    chk("abort_done",    {31'd0, bus.done},    32'd0);
    chk("abort_sig",     {24'd0, bus.signature}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    session(8'hBD, 4'd1, 0, 1'b0, 1'b0, se);       // fresh session after abort

    // Randomized sessions
    for (int t = 0; t < 12; t++)
      session(8'($urandom), 4'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
              1'($urandom), 1'($urandom), se);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_bist_controller.md
SCAN_BIST_CONTROLLER -- requirements
Module: scan_bist_controller

Interface
REQ-001 The parameter list SHALL be: CHAIN_LEN, 8, scan chain length in flops.
REQ-002 The ports SHALL be: clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle request to run a test session; sampled only in IDLE.
REQ-005 seed  in  8  LFSR seed, captured on accepted start.
REQ-006 num_patterns  in  4  patterns per session, captured on accepted start.
REQ-007 scan_out_chain  in  1  registered serial output of the downstream scan chain.
REQ-008 scan_in  out  1  serial pattern bit to the chain.
REQ-009 scan_en  out  1  chain shift enable (1 = shift, 0 = capture).
REQ-010 busy  out  1  high while a session is in LOAD, CAPTURE or UNLOAD.
REQ-011 done  out  1  one-cycle pulse at session end.
REQ-012 signature  out  8  MISR result, held from done until the next accepted start.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, CAPTURE, UNLOAD and DONE; all outputs SHALL be Moore, decoded from registers.
REQ-014 In IDLE with start=1 and num_patterns!=0, the block SHALL latch seed into the pattern LFSR, latch num_patterns, clear the MISR to 8'h00 and go to LOAD.
REQ-015 In IDLE with start=1 and num_patterns==0, the block SHALL go to DONE with no scan activity; signature SHALL read 8'h00.
REQ-016 LOAD SHALL last CHAIN_LEN cycles with scan_en=1 and scan_in = current pattern bit, MSB (bit 7) first; the chain then holds dff = pattern.
REQ-017 CAPTURE SHALL last 1 cycle with scan_en=0 and scan_in=0.
REQ-018 UNLOAD SHALL last CHAIN_LEN+1 cycles with scan_en=1 and scan_in=0; the scan_out_chain sample in UNLOAD cycle 0 SHALL be discarded (stale register), and samples in cycles 1..CHAIN_LEN SHALL feed the MISR.
REQ-019 MISR update per accepted bit: sig <= {sig[6:0], sig[7]^sig[3]^sig[2]^sig[1]^bit}.
REQ-020 At the end of UNLOAD, the pattern LFSR SHALL advance one step: lfsr <= {lfsr[6:0], lfsr[1]^lfsr[2]^lfsr[3]^lfsr[7]}.
REQ-021 At the end of UNLOAD, the pattern counter SHALL decrement; the FSM SHALL go to LOAD if patterns remain, else to DONE.
REQ-022 DONE SHALL last 1 cycle with done=1, busy=0 and scan_en=0, then return to IDLE.
REQ-023 Latency: 18 cycles per pattern; done SHALL be high in cycle 18*N+1 after the start-sampling edge.
REQ-024 start while not in IDLE SHALL be ignored; a start in the DONE cycle SHALL be ignored.
REQ-025 seed=8'h00 SHALL be accepted as-is; the block SHALL emit all-zero patterns (LFSR lock-up, no correction).

Reset
REQ-026 rst_n low SHALL immediately force IDLE and clear all outputs and registers: scan_in=0, scan_en=0, busy=0, done=0, signature=8'h00, LFSR=8'h00, counters=0.
REQ-027 Reset asserted mid-session SHALL abort the session with no done pulse; the next start SHALL begin a fresh session.

Structure
REQ-028 A shared package scan_bist_pkg SHALL hold the FSM state encoding, CHAIN_LEN default, the LFSR tap mask 8'h8E and the MISR tap mask 8'h8E.
REQ-029 The MISR SHALL be a sub-module misr8 (clk, rst_n, clr, en, bit_in, sig); the pattern LFSR, bit counter and pattern counter SHALL stay in the top.

Verification
REQ-030 seed=8'hBD, num_patterns=1, start pulse -> scan_in over the LOAD cycles = 1,0,1,1,1,1,0,1; scan_en = 1×8, 0×1, 1×9; done in cycle 19.
REQ-031 seed=8'hBD, num_patterns=2 -> second LOAD shifts 8'h7B MSB first; done in cycle 37; busy high cycles 1..36.
REQ-032 scan_out_chain tied 1, num_patterns=1 -> signature=8'hDE; scan_out_chain tied 0 -> signature=8'h00.
REQ-033 num_patterns=0 -> done in cycle 1, scan_en never high, signature=8'h00.
REQ-034 rst_n low during UNLOAD of pattern 1 of 3 -> same-cycle busy=0 and scan_en=0, no done; a restart with seed 8'hBD reproduces the REQ-030 sequence.
REQ-035 start re-pulsed during LOAD -> ignored; total session length unchanged.
